// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC interpolator datapath.
package cic_pkg;

  localparam int N_STAGES     = 5;
  localparam int COUNTER_BITS = 16;

  typedef logic [COUNTER_BITS-1:0] count_t;

  // Bits needed to encode values 0..value-1; used for shifter select widths.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Saturation bounds of a signed BITS-wide result, expressed at WIDTH bits.
  function automatic longint sat_max(input int bits);
    return (longint'(1) <<< (bits - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int bits);
    return -(longint'(1) <<< (bits - 1));
  endfunction

endpackage

// File: rtl/cic_shift_sat.sv
// Arithmetic right shift of the last integrator followed by saturation to BITS.
// The output register only advances on i_en so the sample holds between enables.
module cic_shift_sat
  import cic_pkg::*;
#(
  parameter int WIDTH   = 72,
  parameter int BITS    = 16,
  parameter int SHIFT_W = 7
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic [SHIFT_W-1:0]      i_shift,
  output logic signed [BITS-1:0]  o_data
);

  localparam logic signed [WIDTH-1:0] MAX_V = WIDTH'(sat_max(BITS));
  localparam logic signed [WIDTH-1:0] MIN_V = WIDTH'(sat_min(BITS));

  logic signed [WIDTH-1:0] w_shifted;
  logic signed [BITS-1:0]  w_sat;

  always_comb begin
    w_shifted = i_data >>> i_shift;
    if (w_shifted > MAX_V) begin
      w_sat = MAX_V[BITS-1:0];
    end else if (w_shifted < MIN_V) begin
      w_sat = MIN_V[BITS-1:0];
    end else begin
      w_sat = w_shifted[BITS-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data <= '0;
    end else if (i_en) begin
      o_data <= w_sat;
    end
  end

endmodule

// File: rtl/cic_interp.sv
// 5-stage CIC interpolator: low-rate comb chain, zero-stuffing, high-rate integrators,
// then a gain-shifted, saturated output register. One-deep input holding register.
module cic_interp
  import cic_pkg::*;
#(
  parameter int WIDTH      = 72,
  parameter int INTERP     = 8192,
  parameter int BITS       = 16,
  parameter int GAIN_BITS  = 8,
  parameter int BASE_SHIFT = 48
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ce,
  input  logic signed [BITS-1:0]  x_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [GAIN_BITS-1:0]    gain,
  output logic signed [BITS-1:0]  x_out,
  output logic                    out_tick,
  output logic                    underrun
);

  localparam int     SHIFT_W = clog2(WIDTH);
  localparam count_t LAST    = count_t'(INTERP - 1);

  count_t                  r_count;
  logic                    r_hold_full;
  logic signed [BITS-1:0]  r_x_hold;
  logic                    r_underrun;
  logic                    r_out_tick;
  logic signed [WIDTH-1:0] r_comb     [N_STAGES];
  logic signed [WIDTH-1:0] r_comb_del [N_STAGES];
  logic signed [WIDTH-1:0] r_integ    [N_STAGES];

  logic signed [WIDTH-1:0] w_comb_in  [N_STAGES];
  logic signed [WIDTH-1:0] w_u;
  logic                    w_strobe;
  logic                    w_accept;
  logic [SHIFT_W-1:0]      w_shift;
  int                      w_shift_int;

  assign w_strobe = ce && (r_count == '0);
  assign in_ready = ~r_hold_full;
  assign w_accept = in_valid && ~r_hold_full;
  assign underrun = r_underrun;
  assign out_tick = r_out_tick;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else if (ce) begin
      r_count <= (r_count == LAST) ? '0 : r_count + count_t'(1);
    end
  end

  // A strobe with an empty holding register feeds zero and flags underrun;
  // a load in that same cycle is kept for the next strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hold_full <= 1'b0;
      r_x_hold    <= '0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= w_strobe && ~r_hold_full;
      if (w_accept) begin
        r_hold_full <= 1'b1;
        r_x_hold    <= x_in;
      end else if (w_strobe) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_STAGES; k++) begin
      w_comb_in[k] = '0;
    end
    if (r_hold_full) begin
      w_comb_in[0] = {{(WIDTH-BITS){r_x_hold[BITS-1]}}, r_x_hold};
    end
    for (int k = 1; k < N_STAGES; k++) begin
      w_comb_in[k] = r_comb[k-1];
    end
  end

  assign w_u = w_strobe ? r_comb[N_STAGES-1] : '0;

  // Integrators wrap in WIDTH bits by design; the combs cancel the overflow exactly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < N_STAGES; k++) begin
        r_comb[k]     <= '0;
        r_comb_del[k] <= '0;
        r_integ[k]    <= '0;
      end
    end else if (ce) begin
      if (w_strobe) begin
        for (int k = 0; k < N_STAGES; k++) begin
          r_comb_del[k] <= w_comb_in[k];
          r_comb[k]     <= w_comb_in[k] - r_comb_del[k];
        end
      end
      r_integ[0] <= r_integ[0] + w_u;
      for (int k = 1; k < N_STAGES; k++) begin
        r_integ[k] <= r_integ[k] + r_integ[k-1];
      end
    end
  end

  always_comb begin
    w_shift_int = BASE_SHIFT - int'(gain);
    if (w_shift_int < 0) begin
      w_shift_int = 0;
    end else if (w_shift_int > WIDTH - 1) begin
      w_shift_int = WIDTH - 1;
    end
    w_shift = SHIFT_W'(w_shift_int);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_tick <= 1'b0;
    end else begin
      r_out_tick <= ce;
    end
  end

  cic_shift_sat #(
    .WIDTH   (WIDTH),
    .BITS    (BITS),
    .SHIFT_W (SHIFT_W)
  ) u_shift_sat (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_en    (ce),
    .i_data  (r_integ[N_STAGES-1]),
    .i_shift (w_shift),
    .o_data  (x_out)
  );

endmodule

// File: tb/tb_cic_interp.sv
// Self-checking bench for cic_interp: outputs compared against a direct-convolution
// model of the CIC impulse response applied to the zero-stuffed strobe samples.
module tb_cic_interp;

  localparam int WIDTH      = 32;
  localparam int INTERP     = 4;
  localparam int BITS       = 16;
  localparam int GAIN_BITS  = 8;
  localparam int BASE_SHIFT = 8;
  localparam int NTAP       = 5 * (INTERP - 1) + 1;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b1;
  logic                   ce = 1'b0;
  logic                   in_valid = 1'b0;
  logic signed [BITS-1:0] x_in = '0;
  logic [GAIN_BITS-1:0]   gain = '0;
  logic                   in_ready;
  logic                   out_tick;
  logic                   underrun;
  logic signed [BITS-1:0] x_out;

  cic_interp #(
    .WIDTH(WIDTH), .INTERP(INTERP), .BITS(BITS),
    .GAIN_BITS(GAIN_BITS), .BASE_SHIFT(BASE_SHIFT)
  ) dut (
    .CLK(CLK), .RST(RST), .ce(ce), .x_in(x_in), .in_valid(in_valid),
    .in_ready(in_ready), .gain(gain), .x_out(x_out),
    .out_tick(out_tick), .underrun(underrun)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  longint h [NTAP];
  longint tmp [NTAP];
  int     lat = 20;

  logic signed [BITS-1:0] src_q [$];
  longint                 s_q [$];
  logic signed [BITS-1:0] out_q [$];
  logic signed [BITS-1:0] ref_dc [$];

  int     ce_cnt, n_acc, n_under, ready_err, under_err, tick_err;
  bit     pend;
  longint pend_val;

  function automatic longint ref_out(input int i, input int sh);
    longint y;
    int m;
    y = 0;
    for (int k = 0; k < NTAP; k++) begin
      m = i - lat - k;
      if (m >= 0 && (m % INTERP) == 0 && (m / INTERP) < s_q.size())
        y += h[k] * s_q[m / INTERP];
    end
    y = y >>> sh;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  function automatic int eff_shift(input int g);
    return (BASE_SHIFT - g < 0) ? 0 : BASE_SHIFT - g;
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    in_valid = 1'b0;
    ce = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    src_q.delete();
    s_q.delete();
    out_q.delete();
    ce_cnt = 0; n_acc = 0; n_under = 0;
    ready_err = 0; under_err = 0; tick_err = 0;
    pend = 1'b0; pend_val = 0;
  endtask

  task automatic run(input int n_cyc, input bit toggle, input int gap_lo, input int gap_hi);
    bit strobe;
    bit exp_under;
    for (int c = 0; c < n_cyc; c++) begin
      ce = toggle ? ((c % 2) == 0) : 1'b1;
      in_valid = (src_q.size() > 0) && !(c >= gap_lo && c < gap_hi);
      x_in = in_valid ? src_q[0] : '0;
      if (in_ready !== !pend) ready_err++;
      strobe = ce && ((ce_cnt % INTERP) == 0);
      exp_under = strobe && !pend;
      if (strobe) begin
        s_q.push_back(pend ? pend_val : 0);
        pend = 1'b0;
      end
      if (in_valid && in_ready) begin
        pend = 1'b1;
        pend_val = src_q.pop_front();
        n_acc++;
      end
      if (ce) ce_cnt++;
      @(posedge CLK);
      #1;
      if (out_tick !== ce) tick_err++;
      if (underrun !== exp_under) under_err++;
      if (underrun) n_under++;
      if (out_tick) out_q.push_back(x_out);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (x_out !== 16'sd0) begin failures++; $display("FAIL reset_x_out: got %0d want 0", x_out); end
    checks++; if (out_tick !== 1'b0) begin failures++; $display("FAIL reset_out_tick: got %b want 0", out_tick); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_impulse();
    int n0, j0, run_len, nz, asym, bad;
    longint sum;
    do_reset();
    gain = 8'd8;
    src_q.push_back(16'sd1);
    run(120, 1'b0, 0, 0);
    n0 = -1; j0 = -1; nz = 0; sum = 0; run_len = 0; asym = 0; bad = 0;
    foreach (out_q[i]) begin
      if (out_q[i] != 0) begin
        if (n0 < 0) n0 = i;
        nz++;
        sum += out_q[i];
      end
    end
    foreach (s_q[j]) if (s_q[j] == 1 && j0 < 0) j0 = j;
    checks++;
    if (n0 < 0 || j0 < 0) begin
      failures++; $display("FAIL impulse_found: first_nonzero=%0d strobe=%0d want both >=0", n0, j0);
    end else begin
      lat = n0 - j0 * INTERP;
      for (int i = n0; i < out_q.size() && out_q[i] != 0; i++) run_len++;
      for (int k = 0; k < NTAP; k++)
        if (n0 + NTAP - 1 < out_q.size() && out_q[n0 + k] !== out_q[n0 + NTAP - 1 - k]) asym++;
    end
    checks++; if (run_len != 16) begin failures++; $display("FAIL impulse_run_len: got %0d want 16", run_len); end
    checks++; if (nz != 16) begin failures++; $display("FAIL impulse_nonzero: got %0d want 16", nz); end
    checks++; if (sum != 1024) begin failures++; $display("FAIL impulse_sum: got %0d want 1024", sum); end
    checks++; if (asym != 0) begin failures++; $display("FAIL impulse_symmetry: asym=%0d want 0", asym); end
    foreach (out_q[i]) if (longint'(out_q[i]) != ref_out(i, 0)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL impulse_shape: mismatches=%0d want 0", bad); end
    checks++; if (n_under != 29) begin failures++; $display("FAIL impulse_underruns: got %0d want 29", n_under); end
    checks++; if (under_err != 0) begin failures++; $display("FAIL impulse_underrun_timing: errors=%0d want 0", under_err); end
  endtask

  task automatic dc_run(input int g, input int level, input int want);
    int bad, off;
    do_reset();
    gain = GAIN_BITS'(g);
    for (int i = 0; i < 40; i++) src_q.push_back(BITS'(level));
    run(140, 1'b0, 0, 0);
    bad = 0; off = 0;
    foreach (out_q[i]) if (longint'(out_q[i]) != ref_out(i, eff_shift(g))) bad++;
    for (int i = 80; i < 140; i++) if (i >= out_q.size() || out_q[i] != want) off++;
    checks++; if (bad != 0) begin failures++; $display("FAIL dc_model g=%0d x=%0d: mismatches=%0d want 0", g, level, bad); end
    checks++; if (off != 0) begin failures++; $display("FAIL dc_steady g=%0d x=%0d: off=%0d want 0 (value %0d)", g, level, off, want); end
    checks++; if (n_under != 1) begin failures++; $display("FAIL dc_underruns g=%0d: got %0d want 1", g, n_under); end
  endtask

  task automatic test_dc();
    dc_run(0, 1000, 1000);
    ref_dc = out_q;
    dc_run(1, 1000, 2000);
  endtask

  task automatic test_saturation();
    dc_run(6, 1000, 32767);
    dc_run(6, -1000, -32768);
  endtask

  task automatic test_handshake();
    int bad;
    do_reset();
    gain = '0;
    for (int i = 0; i < 40; i++) src_q.push_back(BITS'($urandom_range(0, 65535)));
    run(100, 1'b0, 0, 0);
    checks++; if (n_acc != 25) begin failures++; $display("FAIL hs_accepts: got %0d want 25", n_acc); end
    checks++; if (ready_err != 0) begin failures++; $display("FAIL hs_in_ready: errors=%0d want 0", ready_err); end
    bad = 0;
    foreach (out_q[i]) if (longint'(out_q[i]) != ref_out(i, BASE_SHIFT)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL hs_random_model: mismatches=%0d want 0", bad); end

    do_reset();
    gain = '0;
    for (int i = 0; i < 40; i++) src_q.push_back(BITS'($urandom_range(0, 65535)));
    run(100, 1'b0, 5, 9);
    checks++; if (n_under != 2) begin failures++; $display("FAIL hs_withhold_underruns: got %0d want 2", n_under); end
    checks++; if (s_q.size() < 4 || s_q[2] != 0) begin failures++; $display("FAIL hs_withhold_zero: strobes=%0d want slot 2 zero", s_q.size()); end
    bad = 0;
    foreach (out_q[i]) if (longint'(out_q[i]) != ref_out(i, BASE_SHIFT)) bad++;
    checks++; if (bad != 0 || under_err != 0) begin failures++; $display("FAIL hs_withhold_model: mismatches=%0d underrun_err=%0d want 0", bad, under_err); end
  endtask

  task automatic test_random_gain();
    int g, bad;
    for (int t = 0; t < 2; t++) begin
      g = (t == 0) ? int'($urandom_range(0, 12)) : 255;
      do_reset();
      gain = GAIN_BITS'(g);
      for (int i = 0; i < 40; i++) src_q.push_back(BITS'($urandom_range(0, 65535)));
      run(120, 1'b0, 0, 0);
      bad = 0;
      foreach (out_q[i]) if (longint'(out_q[i]) != ref_out(i, eff_shift(g))) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL random_gain g=%0d: mismatches=%0d want 0", g, bad); end
    end
  endtask

  task automatic test_ce_gating();
    int bad;
    do_reset();
    gain = '0;
    for (int i = 0; i < 40; i++) src_q.push_back(16'sd1000);
    run(280, 1'b1, 0, 0);
    checks++; if (tick_err != 0) begin failures++; $display("FAIL ce_out_tick: errors=%0d want 0", tick_err); end
    checks++; if (out_q.size() != 140) begin failures++; $display("FAIL ce_output_count: got %0d want 140", out_q.size()); end
    bad = 0;
    for (int i = 0; i < 140; i++) if (i >= out_q.size() || i >= ref_dc.size() || out_q[i] !== ref_dc[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL ce_sequence: mismatches=%0d want 0", bad); end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    gain = '0;
    for (int i = 0; i < 40; i++) src_q.push_back(16'sd1000);
    run(60, 1'b0, 0, 0);
    RST = 1'b1;
    ce = 1'b1;
    @(posedge CLK);
    #1;
    checks++; if (x_out !== 16'sd0) begin failures++; $display("FAIL midreset_x_out: got %0d want 0", x_out); end
    checks++; if (out_tick !== 1'b0) begin failures++; $display("FAIL midreset_out_tick: got %b want 0", out_tick); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
    do_reset();
    gain = '0;
    for (int i = 0; i < 40; i++) src_q.push_back(16'sd1000);
    run(140, 1'b0, 0, 0);
    bad = 0;
    for (int i = 0; i < 140; i++) if (i >= out_q.size() || i >= ref_dc.size() || out_q[i] !== ref_dc[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL midreset_restart: mismatches=%0d want 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < NTAP; i++) h[i] = 0;
    h[0] = 1;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < NTAP; i++) tmp[i] = 0;
      for (int i = 0; i < NTAP; i++)
        for (int j = 0; j < INTERP; j++)
          if (i + j < NTAP) tmp[i + j] += h[i];
      h = tmp;
    end

    test_reset();
    test_impulse();
    test_dc();
    test_saturation();
    test_handshake();
    test_random_gain();
    test_ce_gating();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
